// File: rtl/fft_bin_streamer.sv
// Snapshots a parallel FFT result and streams it one bin per valid/ready beat.
// Optional magnitude estimate |re|+|im| is enabled by defining FFT_BIN_MAG_EN.
module fft_bin_streamer #(
    parameter  int N_BINS = 8,
    parameter  int DATA_W = 12,
    localparam int IDX_W  = $clog2(N_BINS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               fft_done,
    input  logic [0:N_BINS-1][DATA_W-1:0]      fft_re,
    input  logic [0:N_BINS-1][DATA_W-1:0]      fft_im,
    output logic                               bin_valid,
    input  logic                               bin_ready,
    output logic [DATA_W-1:0]                  bin_re,
    output logic [DATA_W-1:0]                  bin_im,
    output logic [IDX_W-1:0]                   bin_idx,
    output logic                               bin_last,
    output logic [DATA_W:0]                    bin_mag,
    output logic                               busy,
    output logic                               overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic                             last_q, last_d;
    logic                             overrun_q, overrun_d;
    logic [0:N_BINS-1][DATA_W-1:0]    shadow_re_q, shadow_re_d;
    logic [0:N_BINS-1][DATA_W-1:0]    shadow_im_q, shadow_im_d;
    logic                             xfer;
    logic                             capture;

    // A new frame is only taken in IDLE or on the very beat that retires the last bin.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        overrun_d   = overrun_q;
        shadow_re_d = shadow_re_q;
        shadow_im_d = shadow_im_q;
        capture     = 1'b0;
        xfer        = (state_q == S_STREAM) && bin_ready;

        case (state_q)
            S_IDLE: begin
                if (fft_done) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (xfer && (idx_q == LAST_IDX)) begin
                    if (fft_done) begin
                        capture = 1'b1;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (fft_done) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture) begin
            shadow_re_d = fft_re;
            shadow_im_d = fft_im;
        end

        last_d = (state_d == S_STREAM) && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            last_q      <= 1'b0;
            overrun_q   <= 1'b0;
            shadow_re_q <= '0;
            shadow_im_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            overrun_q   <= overrun_d;
            shadow_re_q <= shadow_re_d;
            shadow_im_q <= shadow_im_d;
        end
    end

    assign bin_valid = (state_q == S_STREAM);
    assign busy      = (state_q == S_STREAM);
    assign bin_idx   = idx_q;
    assign bin_last  = last_q;
    assign overrun   = overrun_q;
    assign bin_re    = shadow_re_q[idx_q];
    assign bin_im    = shadow_im_q[idx_q];

`ifdef FFT_BIN_MAG_EN
    logic [DATA_W-1:0] abs_re;
    logic [DATA_W-1:0] abs_im;

    // Two's-complement negate of the most negative value yields exactly 2^(DATA_W-1) unsigned.
    assign abs_re  = bin_re[DATA_W-1] ? (~bin_re + DATA_W'(1)) : bin_re;
    assign abs_im  = bin_im[DATA_W-1] ? (~bin_im + DATA_W'(1)) : bin_im;
    assign bin_mag = {1'b0, abs_re} + {1'b0, abs_im};
`else
    assign bin_mag = '0;
`endif

endmodule

// File: tb/tb_fft_bin_streamer.sv
// Directed scoreboard bench for fft_bin_streamer (default N_BINS=8, DATA_W=12).
module tb_fft_bin_streamer;

    logic               clk;
    logic               rst_n;
    logic               fft_done;
    logic [0:7][11:0]   fft_re;
    logic [0:7][11:0]   fft_im;
    logic               bin_valid;
    logic               bin_ready;
    logic [11:0]        bin_re;
    logic [11:0]        bin_im;
    logic [2:0]         bin_idx;
    logic               bin_last;
    logic [12:0]        bin_mag;
    logic               busy;
    logic               overrun;

    typedef struct {
        logic [2:0]  idx;
        logic [11:0] re;
        logic [11:0] im;
        logic [12:0] mag;
        logic        last;
    } beat_t;

    beat_t              sb[$];
    beat_t              exp_b;
    logic signed [11:0] fr_re [8];
    logic signed [11:0] fr_im [8];
    int                 total;
    int                 bad;
    int                 cycles;

    fft_bin_streamer #(.N_BINS(8), .DATA_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fft_done  (fft_done),
        .fft_re    (fft_re),
        .fft_im    (fft_im),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready),
        .bin_re    (bin_re),
        .bin_im    (bin_im),
        .bin_idx   (bin_idx),
        .bin_last  (bin_last),
        .bin_mag   (bin_mag),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] magOf(input logic signed [11:0] r, input logic signed [11:0] i);
`ifdef FFT_BIN_MAG_EN
        int ar;
        int ai;
        ar = (r < 0) ? -int'(r) : int'(r);
        ai = (i < 0) ? -int'(i) : int'(i);
        return 13'(ar + ai);
`else
        return (r === i) ? 13'd0 : 13'd0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    // Drives the frame held in fr_re/fr_im and, when it should be accepted, queues its beats.
    task automatic applyStimulus(input bit accepted);
        beat_t b;
        for (int k = 0; k < 8; k++) begin
            fft_re[k] = fr_re[k];
            fft_im[k] = fr_im[k];
            if (accepted) begin
                b.idx  = 3'(k);
                b.re   = fr_re[k];
                b.im   = fr_im[k];
                b.mag  = magOf(fr_re[k], fr_im[k]);
                b.last = (k == 7);
                sb.push_back(b);
            end
        end
        fft_done = 1'b1;
    endtask

    task automatic drainFrame(input bit toggle, output int n);
        n = 0;
        do begin
            waitEdge();
            n++;
            if (toggle) bin_ready = ~bin_ready;
        end while (sb.size() != 0 && n < 200);
    endtask

    // Every presented beat is compared against the scoreboard head; it pops only on a transfer.
    always @(negedge clk) begin : monitor
        if (rst_n && bin_valid) begin
            checkOutput("beat_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_b = sb[0];
                checkOutput("bin_idx", 32'(bin_idx), 32'(exp_b.idx));
                checkOutput("bin_re", 32'(bin_re), 32'(exp_b.re));
                checkOutput("bin_im", 32'(bin_im), 32'(exp_b.im));
                checkOutput("bin_last", 32'(bin_last), 32'(exp_b.last));
                checkOutput("bin_mag", 32'(bin_mag), 32'(exp_b.mag));
                if (bin_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        fft_done  = 1'b0;
        bin_ready = 1'b0;
        fft_re    = '0;
        fft_im    = '0;
        #12;
        checkOutput("rst_valid", 32'(bin_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_last", 32'(bin_last), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_idx", 32'(bin_idx), 32'd0);
        checkOutput("rst_re", 32'(bin_re), 32'd0);
        checkOutput("rst_im", 32'(bin_im), 32'd0);
        checkOutput("rst_mag", 32'(bin_mag), 32'd0);
        rst_n = 1'b1;
        waitEdge();

        $display("[TB] single frame, ready held high");
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 12'(k * 100);
            fr_im[k] = 12'(-k);
        end
        bin_ready = 1'b1;
        applyStimulus(1'b1);
        waitEdge();
        fft_done = 1'b0;
        checkOutput("latency_valid", 32'(bin_valid), 32'd1);
        checkOutput("latency_idx", 32'(bin_idx), 32'd0);
        drainFrame(1'b0, cycles);
        checkOutput("frame1_cycles", 32'(cycles), 32'd8);
        checkOutput("frame1_busy_end", 32'(busy), 32'd0);
        checkOutput("frame1_valid_end", 32'(bin_valid), 32'd0);

        $display("[TB] backpressure, ready toggling");
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 12'(-(k * 37 + 11));
            fr_im[k] = 12'(k * 250 - 900);
        end
        applyStimulus(1'b1);
        waitEdge();
        fft_done  = 1'b0;
        bin_ready = 1'b0;
        drainFrame(1'b1, cycles);
        checkOutput("bp_cycles", 32'(cycles), 32'd16);
        checkOutput("bp_busy_end", 32'(busy), 32'd0);
        bin_ready = 1'b1;
        waitEdge();

        $display("[TB] back-to-back frames");
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 12'(k * 10 + 1);
            fr_im[k] = 12'(k);
        end
        applyStimulus(1'b1);
        waitEdge();
        fft_done = 1'b0;
        repeat (7) waitEdge();
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 12'd5;
            fr_im[k] = 12'(-2 * k);
        end
        applyStimulus(1'b1);
        waitEdge();
        fft_done = 1'b0;
        checkOutput("b2b_valid", 32'(bin_valid), 32'd1);
        checkOutput("b2b_idx", 32'(bin_idx), 32'd0);
        checkOutput("b2b_re", 32'(bin_re), 32'd5);
        drainFrame(1'b0, cycles);
        checkOutput("b2b_cycles", 32'(cycles), 32'd8);
        checkOutput("b2b_overrun", 32'(overrun), 32'd0);

        $display("[TB] overrun while stalled at idx 3");
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 12'(300 - k * 3);
            fr_im[k] = 12'(k * 7);
        end
        applyStimulus(1'b1);
        waitEdge();
        fft_done = 1'b0;
        repeat (3) waitEdge();
        bin_ready = 1'b0;
        waitEdge();
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 12'h7ff;
            fr_im[k] = 12'h123;
        end
        applyStimulus(1'b0);
        waitEdge();
        fft_done = 1'b0;
        checkOutput("ovr_flag", 32'(overrun), 32'd1);
        checkOutput("ovr_idx_held", 32'(bin_idx), 32'd3);
        waitEdge();
        bin_ready = 1'b1;
        drainFrame(1'b0, cycles);
        checkOutput("ovr_sticky", 32'(overrun), 32'd1);
        checkOutput("ovr_busy_end", 32'(busy), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("ovr_cleared_by_reset", 32'(overrun), 32'd0);
        #2;
        rst_n = 1'b1;
        waitEdge();

        $display("[TB] magnitude corners");
        fr_re[0] = 12'h800;
        fr_im[0] = 12'h800;
        fr_re[1] = 12'sd7;
        fr_im[1] = -12'sd3;
        for (int k = 2; k < 8; k++) begin
            fr_re[k] = 12'($urandom);
            fr_im[k] = 12'($urandom);
        end
        applyStimulus(1'b1);
        waitEdge();
        fft_done = 1'b0;
`ifdef FFT_BIN_MAG_EN
        checkOutput("mag_min_neg", 32'(bin_mag), 32'd4096);
`else
        checkOutput("mag_disabled", 32'(bin_mag), 32'd0);
`endif
        drainFrame(1'b0, cycles);
        checkOutput("mag_cycles", 32'(cycles), 32'd8);

        $display("[TB] reset mid-frame");
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 12'(k * 3 - 12);
            fr_im[k] = 12'(k * 111);
        end
        applyStimulus(1'b1);
        waitEdge();
        fft_done = 1'b0;
        repeat (4) waitEdge();
        checkOutput("mid_idx_before", 32'(bin_idx), 32'd4);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_valid_async", 32'(bin_valid), 32'd0);
        checkOutput("mid_idx_async", 32'(bin_idx), 32'd0);
        checkOutput("mid_busy_async", 32'(busy), 32'd0);
        checkOutput("mid_re_async", 32'(bin_re), 32'd0);
        sb.delete();
        #2;
        rst_n = 1'b1;
        waitEdge();
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 12'(k * 200 - 800);
            fr_im[k] = 12'(5 - k);
        end
        applyStimulus(1'b1);
        waitEdge();
        fft_done = 1'b0;
        checkOutput("post_rst_idx", 32'(bin_idx), 32'd0);
        checkOutput("post_rst_valid", 32'(bin_valid), 32'd1);
        drainFrame(1'b0, cycles);
        checkOutput("post_rst_cycles", 32'(cycles), 32'd8);
        checkOutput("post_rst_busy_end", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
